// File: rtl/param_swap_pkg.sv
// Shared definitions for the reordering register bank: op encodings, FSM states
// and the index helper used by the reverse sequence.
package param_swap_pkg;

    typedef enum logic [1:0] {
        OP_SWAP = 2'b00,
        OP_ROTL = 2'b01,
        OP_REV  = 2'b10,
        OP_NOP  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MV,
        S_WB,
        S_ROT,
        S_DONE
    } state_t;

    // Partner of entry k when the bank is reversed.
    function automatic int unsigned mirror_idx(input int unsigned k, input int unsigned nregs);
        return nregs - 1 - k;
    endfunction

endpackage

// File: rtl/swap_bank_regfile.sv
// WIDTH x NREGS storage: async clear, one write port, whole-bank combinational
// view, and a single-cycle rotate-left of all entries.
module swap_bank_regfile #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    localparam int IDXW = $clog2(NREGS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we,
    input  logic [IDXW-1:0]               waddr,
    input  logic [WIDTH-1:0]              wdata,
    input  logic                          rot_en,
    output logic [NREGS-1:0][WIDTH-1:0]   q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (rot_en) begin
            // entry[n] takes entry[n+1]; entry[0] wraps into the top slot
            q <= {q[0], q[NREGS-1:1]};
        end else if (we) begin
            q[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/param_swap_bank.sv
// Register bank that swaps, rotates or reverses its entries on command, with a
// load port, a command handshake, a done pulse and a completed-command counter.
module param_swap_bank
    import param_swap_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int CNTW  = 16,
    localparam int IDXW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDXW-1:0]  wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [IDXW-1:0]  cmd_i,
    input  logic [IDXW-1:0]  cmd_j,
    input  logic [IDXW-1:0]  rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic [CNTW-1:0]  cmd_count
);

    localparam logic [IDXW-1:0] K_LAST = IDXW'(NREGS / 2 - 1);

    state_t                      state;
    op_t                         op_r;
    logic [IDXW-1:0]             i_r, j_r, k_r;
    logic [IDXW-1:0]             addr_a, addr_b;
    logic [WIDTH-1:0]            tmp_r;
    logic [CNTW-1:0]             cnt_r;
    logic                        busy_r, done_r;
    logic [NREGS-1:0][WIDTH-1:0] q;
    logic                        we, rot_en;
    logic [IDXW-1:0]             waddr;
    logic [WIDTH-1:0]            wdata;

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // op/i/j are captured there and the host may change them afterwards. A pending
    // load owns the idle cycle, so the host keeps cmd_valid up until it is taken.
    assign cmd_ready = (state == S_IDLE) && !wr_en && !rst;

    // The reverse walk reuses the swap micro-sequence with a pair derived from k.
    assign addr_a = (op_r == OP_REV) ? k_r : i_r;
    assign addr_b = (op_r == OP_REV) ? IDXW'(mirror_idx(32'(k_r), NREGS)) : j_r;

    always_comb begin
        we     = 1'b0;
        waddr  = wr_idx;
        wdata  = wr_data;
        rot_en = (state == S_ROT);
        case (state)
            S_IDLE: we = wr_en;
            S_MV: begin
                we    = 1'b1;
                waddr = addr_a;
                wdata = q[addr_b];
            end
            S_WB: begin
                we    = 1'b1;
                waddr = addr_b;
                wdata = tmp_r;
            end
            default: ;
        endcase
    end

    swap_bank_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .rot_en (rot_en),
        .q      (q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            op_r   <= OP_SWAP;
            i_r    <= '0;
            j_r    <= '0;
            k_r    <= '0;
            tmp_r  <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_r   <= op_t'(cmd_op);
                        i_r    <= cmd_i;
                        j_r    <= cmd_j;
                        k_r    <= '0;
                        busy_r <= 1'b1;
                        case (op_t'(cmd_op))
                            OP_SWAP, OP_REV: state <= S_RD;
                            OP_ROTL:         state <= S_ROT;
                            default: begin
                                state  <= S_DONE;
                                done_r <= 1'b1;
                            end
                        endcase
                    end
                end
                S_RD: begin
                    tmp_r <= q[addr_a];
                    state <= S_MV;
                end
                S_MV: state <= S_WB;
                S_WB: begin
                    if (op_r == OP_REV && k_r < K_LAST) begin
                        k_r   <= k_r + 1'b1;
                        state <= S_RD;
                    end else begin
                        state  <= S_DONE;
                        done_r <= 1'b1;
                    end
                end
                S_ROT: begin
                    state  <= S_DONE;
                    done_r <= 1'b1;
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    cnt_r  <= cnt_r + 1'b1;
                end
                default: begin
                    state  <= S_IDLE;
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data   = q[rd_idx];
    assign busy      = busy_r;
    assign done      = done_r;
    assign cmd_count = cnt_r;

endmodule

// File: doc/param_swap_bank.md
Name: param_swap_bank

Overview:
- Parametrised register bank of NREGS entries, each WIDTH bits, that reorders its contents on command.
- Supported commands: swap two entries through a temporary register, rotate left by one, full reverse, and no-op.
- Successor to the fixed two-register 8-bit swapper: generalised width and depth, with a load port, a valid/ready command handshake, a multi-cycle FSM and a completion pulse.
- Sits between a host/testbench driver and any datapath that reads the bank back.

Parameters:
- WIDTH, 8, bits per register entry.
- NREGS, 4, number of entries; must be a power of 2 and at least 2.
- IDXW, $clog2(NREGS), index width. Derived; never overridden.
- CNTW, 16, width of the completed-command counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- wr_en  input  1  load strobe; honoured only while idle
- wr_idx  input  IDXW  load target entry
- wr_data  input  WIDTH  load value
- cmd_valid  input  1  command request
- cmd_ready  output  1  command can be accepted this cycle
- cmd_op  input  2  00 SWAP, 01 ROTL, 10 REVERSE, 11 NOP
- cmd_i  input  IDXW  first swap index; ignored for other ops
- cmd_j  input  IDXW  second swap index; ignored for other ops
- rd_idx  input  IDXW  read address
- rd_data  output  WIDTH  combinational read of entry rd_idx
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse when a command completes
- cmd_count  output  CNTW  number of completed commands

Behaviour:
- Reset (asynchronous assert):
  - all entries, tmp, op, i, j and pair index k cleared to 0; state set to IDLE.
  - busy=0, done=0, cmd_count=0.
  - cmd_ready is forced to 0 while rst is high.
- Reset mid-command aborts the command immediately. Partially swapped contents are lost, because all entries clear.
- cmd_ready = (state==IDLE) && !wr_en && !rst.
- A command is accepted on the edge where cmd_valid && cmd_ready. At acceptance, op, i and j are latched. Input changes after acceptance have no effect.
- Load:
  - When wr_en is high and state is IDLE, entry[wr_idx] <= wr_data at the edge.
  - A load has priority over a command in the same cycle. cmd_ready is low that cycle, so the command is not accepted and the host holds cmd_valid.
  - wr_en while busy is ignored and has no side effect.
- States: IDLE, RD, MV, WB, ROT, DONE.
- SWAP, with acceptance at edge E0:
  - E0: IDLE->RD.
  - E1: tmp <= entry[i]; RD->MV.
  - E2: entry[i] <= entry[j]; MV->WB.
  - E3: entry[j] <= tmp; WB->DONE.
  - During the cycle after E3, done=1 and the new contents are visible on rd_data.
  - E4: DONE->IDLE and cmd_count increments. cmd_ready is high again after E4.
- SWAP with i==j runs the full sequence, leaves contents unchanged, and still counts.
- ROTL: IDLE->ROT. At the ROT edge, entry[n] <= entry[n+1] for n<NREGS-1, and entry[NREGS-1] <= entry[0], all simultaneously. Then ROT->DONE. done is high 2 cycles after acceptance.
- REVERSE:
  - k starts at 0. For each k, run RD/MV/WB with i=k and j=NREGS-1-k.
  - After WB, if k < NREGS/2-1, then k++ and return to RD; otherwise go to DONE.
  - Total is 3*NREGS/2 cycles, then DONE.
  - NREGS=2 behaves the same as SWAP(0,1).
- NOP: IDLE->DONE. The done pulse arrives one cycle after acceptance, and cmd_count increments.
- cmd_count wraps from 2^CNTW-1 to 0 without saturation.
- Back-to-back commands: the earliest next acceptance is the cycle after DONE. There is no accept in DONE.
- Any unused encoding drives the FSM to IDLE.

Decomposition:
- Shared package param_swap_pkg holds:
  - the op encodings OP_SWAP, OP_ROTL, OP_REV, OP_NOP;
  - the state enum;
  - a helper function mirror_idx(k) returning NREGS-1-k.
- One natural sub-module, swap_bank_regfile: the WIDTH x NREGS storage with an async clear, one write port, combinational read, and a rotate-enable input.
- The FSM, tmp register and counter live in the top level.

Test Plan:
1. WIDTH=8, NREGS=4: load AA,55,0F,F0 into entries 0..3; SWAP(0,1) -> done exactly 4 cycles after accept; entries 55,AA,0F,F0; cmd_count=1.
2. From those contents, ROTL -> AA,0F,F0,55 with done 2 cycles after accept; then REVERSE -> 55,F0,0F,AA with done 7 cycles after accept; cmd_count=3.
3. SWAP(2,2) -> contents unchanged, done after 4 cycles, count increments. NOP -> done 1 cycle after accept.
4. Simultaneous wr_en and cmd_valid in IDLE: write lands, cmd_ready=0, command is accepted the next cycle. wr_en=1 with value 77 during busy -> no entry changes.
5. Assert rst in the MV cycle of a SWAP -> immediate busy=0, all entries 00, cmd_count=0, no done pulse. After release, cmd_ready=1.
6. Preload cmd_count to FFFF via 65535 NOPs (or force in bench), then one NOP -> cmd_count wraps to 0000. WIDTH=16, NREGS=8 REVERSE of 0..7 -> 7..0 in 12 cycles.
